// File: rtl/fft_addr_gen.sv
// Self-sequencing butterfly address generator for an in-place radix-2 FFT.
// Optional build macro: FFT_ADDR_BITREV_EN (bit-reversed working address layout).
module fft_addr_gen #(
    parameter int LOG2N     = 4,
    parameter int STAGE_GAP = 2,
    localparam int SW       = (LOG2N > 2) ? $clog2(LOG2N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ready,
    output logic             valid,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] twiddle_idx,
    output logic [SW-1:0]    stage,
    output logic             last_stage,
    output logic             busy,
    output logic             done
);
    localparam int JW = LOG2N - 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
    localparam logic [JW-1:0]    J_LAST = '1;
    localparam logic [JW-1:0]    J_ONE  = JW'(1);
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
    localparam logic [SW-1:0]    S_ONE  = SW'(1);
    localparam logic [GW-1:0]    G_LAST = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
    localparam logic [GW-1:0]    G_ONE  = GW'(1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    typedef struct packed {
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [LOG2N-2:0] tw;
    } triple_t;

    state_t         state;
    logic [JW-1:0]  j;
    logic [GW-1:0]  gcnt;

`ifdef FFT_ADDR_BITREV_EN
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++)
            r[i] = x[LOG2N-1-i];
        return r;
    endfunction
`endif

    // Butterfly j of stage s pairs samples half apart inside groups of 2*half.
    function automatic triple_t calc(input logic [SW-1:0] s, input logic [JW-1:0] jj);
        triple_t          t;
        logic [LOG2N-1:0] jx, half, grp, pos, a, twf;
        jx   = {1'b0, jj};
        half = ONE << s;
        grp  = jx >> s;
        pos  = jx & (half - ONE);
        a    = (grp << (int'(s) + 1)) | pos;
        twf  = pos << (LOG2N - 1 - int'(s));
`ifdef FFT_ADDR_BITREV_EN
        t.a  = bitrev(a);
        t.b  = bitrev(a | half);
`else
        t.a  = a;
        t.b  = a | half;
`endif
        t.tw = twf[LOG2N-2:0];
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            stage       <= '0;
            j           <= '0;
            gcnt        <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            last_stage  <= 1'b0;
            {addr_a, addr_b, twiddle_idx} <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        stage      <= '0;
                        j          <= '0;
                        {addr_a, addr_b, twiddle_idx} <= calc('0, '0);
                        valid      <= 1'b1;
                        busy       <= 1'b1;
                        last_stage <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (ready) begin
                        if (j != J_LAST) begin
                            j <= j + J_ONE;
                            {addr_a, addr_b, twiddle_idx} <= calc(stage, j + J_ONE);
                        end else if (stage != S_LAST) begin
                            j     <= '0;
                            stage <= stage + S_ONE;
                            if (STAGE_GAP == 0) begin
                                {addr_a, addr_b, twiddle_idx} <= calc(stage + S_ONE, '0);
                                last_stage <= ((stage + S_ONE) == S_LAST);
                            end else begin
                                valid      <= 1'b0;
                                last_stage <= 1'b0;
                                gcnt       <= '0;
                                state      <= GAP;
                            end
                        end else begin
                            valid      <= 1'b0;
                            busy       <= 1'b0;
                            last_stage <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                GAP: begin
                    // stage/j already point at the next stage's first butterfly
                    if (gcnt == G_LAST) begin
                        {addr_a, addr_b, twiddle_idx} <= calc(stage, '0);
                        valid      <= 1'b1;
                        last_stage <= (stage == S_LAST);
                        state      <= RUN;
                    end else begin
                        gcnt <= gcnt + G_ONE;
                    end
                end
                DONE: begin
                    stage <= '0;
                    j     <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: LOG2N=3/GAP=2 and LOG2N=4/GAP=0 instances.
module tb_fft_addr_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start3 = 1'b0, ready3 = 1'b0, start4 = 1'b0, ready4 = 1'b0;
    logic       v3, ls3, busy3, d3, v4, ls4, busy4, d4;
    logic [2:0] a3, b3;
    logic [1:0] tw3, st3;
    logic [3:0] a4, b4;
    logic [2:0] tw4;
    logic [1:0] st4;

    fft_addr_gen #(.LOG2N(3), .STAGE_GAP(2)) u3 (
        .clk(clk), .rst(rst), .start(start3), .ready(ready3), .valid(v3),
        .addr_a(a3), .addr_b(b3), .twiddle_idx(tw3), .stage(st3),
        .last_stage(ls3), .busy(busy3), .done(d3)
    );
    fft_addr_gen #(.LOG2N(4), .STAGE_GAP(0)) u4 (
        .clk(clk), .rst(rst), .start(start4), .ready(ready4), .valid(v4),
        .addr_a(a4), .addr_b(b4), .twiddle_idx(tw4), .stage(st4),
        .last_stage(ls4), .busy(busy4), .done(d4)
    );

    typedef struct { int a; int b; int tw; int st; int ls; int cyc; } exp_t;
    exp_t q3[$];
    exp_t q4[$];

    localparam int A3[12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    localparam int B3[12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    localparam int T3[12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};
    localparam int A4[32] = '{0,2,4,6,8,10,12,14, 0,1,4,5,8,9,12,13,
                              0,1,2,3,8,9,10,11, 0,1,2,3,4,5,6,7};
    localparam int B4[32] = '{1,3,5,7,9,11,13,15, 2,3,6,7,10,11,14,15,
                              4,5,6,7,12,13,14,15, 8,9,10,11,12,13,14,15};
    localparam int T4[32] = '{0,0,0,0,0,0,0,0, 0,4,0,4,0,4,0,4,
                              0,2,4,6,0,2,4,6, 0,1,2,3,4,5,6,7};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0, miscompares = 0;
    int base[2]     = '{0, 0};
    int exp_done[2] = '{-1, -1};
    int done_cnt[2] = '{0, 0};
    bit hold_v[2]   = '{0, 0};
    int hold_w[2]   = '{0, 0};

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int brev(input int x, input int w);
        int r = 0;
        for (int i = 0; i < w; i++)
            if (((x >> i) & 1) != 0) r |= 1 << (w - 1 - i);
        return r;
    endfunction

    task automatic mon(input int k, input logic v, input logic r, input logic d,
                       input logic ls, input int a, input int b, input int tw, input int st);
        exp_t e;
        bit   got;
        int   rel, w;
        rel = cyc - base[k] + 1;
        w   = (int'(v) << 24) | (a << 16) | (b << 8) | tw;
        if (hold_v[k]) chk("hold_stable", w, hold_w[k]);
        if (v && r) begin
            got = 1'b0;
            if (k == 0 && q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end
            if (k == 1 && q4.size() > 0) begin e = q4.pop_front(); got = 1'b1; end
            if (!got) chk("extra_triple", 1, 0);
            else begin
                chk("addr_a", a, e.a);
                chk("addr_b", b, e.b);
                chk("twiddle_idx", tw, e.tw);
                chk("stage", st, e.st);
                chk("last_stage", int'(ls), e.ls);
                if (e.cyc >= 0) chk("valid_cycle", rel, e.cyc);
            end
        end
        hold_v[k] = v && !r;
        hold_w[k] = w;
        if (d) begin
            done_cnt[k]++;
            if (exp_done[k] >= 0) chk("done_cycle", rel, exp_done[k]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, v3, ready3, d3, ls3, int'(a3), int'(b3), int'(tw3), int'(st3));
            mon(1, v4, ready4, d4, ls4, int'(a4), int'(b4), int'(tw4), int'(st4));
        end
    end

    task automatic push_run(input int k, input bit timed, input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            if (k == 0) begin
                e = '{A3[i], B3[i], T3[i], i / 4, int'(i / 4 == 2), timed ? i + 1 + 2 * (i / 4) : -1};
`ifdef FFT_ADDR_BITREV_EN
                e.a = brev(e.a, 3); e.b = brev(e.b, 3);
`endif
                q3.push_back(e);
            end else begin
                e = '{A4[i], B4[i], T4[i], i / 8, int'(i / 8 == 3), timed ? i + 1 : -1};
`ifdef FFT_ADDR_BITREV_EN
                e.a = brev(e.a, 4); e.b = brev(e.b, 4);
`endif
                q4.push_back(e);
            end
        end
    endtask

    task automatic go(input int k);
        @(posedge clk); #1;
        if (k == 0) start3 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        base[k] = cyc;
        start3 = 1'b0;
        start4 = 1'b0;
    endtask

    // bp: ready follows a 1,0,0,1 pattern and a stray start is pulsed mid-run
    task automatic wait_done(input int k, input bit bp);
        int d0;
        d0 = done_cnt[k];
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (done_cnt[k] != d0) break;
            if (bp) begin
                ready3 = (n % 4 == 0) || (n % 4 == 3);
                start3 = (n == 3 || n == 4);
            end
        end
        start3 = 1'b0;
        chk("done_pulses", done_cnt[k] - d0, 1);
        chk("queue_drained", (k == 0) ? q3.size() : q4.size(), 0);
    endtask

    initial begin
        int d0;
        // reset held with start high: rst must win
        rst = 1'b1; start3 = 1'b1; start4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(v3), 0);
        chk("rst_busy", int'(busy3), 0);
        chk("rst_done", int'(d3), 0);
        chk("rst_last_stage", int'(ls3), 0);
        chk("rst_addr", (int'(a3) << 8) | int'(b3), 0);
        chk("rst_twiddle", int'(tw3), 0);
        chk("rst_stage", int'(st3), 0);
        rst = 1'b0; start3 = 1'b0; start4 = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_rst", (int'(v3) << 1) | int'(busy3), 0);

        // full LOG2N=3 sequence with exact cycle positions
        ready3 = 1'b1;
        push_run(0, 1'b1, 12);
        exp_done[0] = 17;
        go(0);
        wait_done(0, 1'b0);
        exp_done[0] = -1;

        // backpressure
        push_run(0, 1'b0, 12);
        go(0);
        wait_done(0, 1'b1);
        ready3 = 1'b1;

        // LOG2N=4 without gaps
        ready4 = 1'b1;
        push_run(1, 1'b1, 32);
        exp_done[1] = 33;
        go(1);
        wait_done(1, 1'b0);

        // reset after the 5th accepted triple
        push_run(0, 1'b0, 5);
        go(0);
        for (int n = 0; n < 50 && q3.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("five_accepted", q3.size(), 0);
        d0 = done_cnt[0];
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", int'(v3), 0);
        chk("midrst_busy", int'(busy3), 0);
        chk("midrst_stage", int'(st3), 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt[0] - d0, 0);
        push_run(0, 1'b0, 12);
        go(0);
        wait_done(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
